// File: rtl/sq_pkg.sv
// Shared types and constants for the code-length run-length compactor.
// Symbol codes, run limits, extra-bit widths, the emitted-symbol record and the scan FSM states.
package sq_pkg;

    localparam logic [4:0] SYM_REP_PREV = 5'd16;
    localparam logic [4:0] SYM_REP_Z3   = 5'd17;
    localparam logic [4:0] SYM_REP_Z11  = 5'd18;

    // Minimum and maximum run lengths each repeat symbol can cover
    localparam int REP_PREV_MIN = 3;
    localparam int REP_PREV_MAX = 6;
    localparam int REP_Z3_MIN   = 3;
    localparam int REP_Z3_MAX   = 10;
    localparam int REP_Z11_MIN  = 11;
    localparam int REP_Z11_MAX  = 138;

    localparam logic [2:0] EXT_LEN_PREV = 3'd2;
    localparam logic [2:0] EXT_LEN_Z3   = 3'd3;
    localparam logic [2:0] EXT_LEN_Z11  = 3'd7;

    typedef struct packed {
        logic [4:0] sym;
        logic [6:0] ext;
        logic [2:0] ext_len;
    } sq_sym_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CMP,
        ST_EMIT,
        ST_DONE
    } sq_cmp_state_e;

endpackage

// File: rtl/sq_run_split.sv
// Combinational greedy splitter: picks the next symbol for a run of n copies of cur_val.
// Zero latency; no flow control of its own, the caller decides when to consume the result.
// Backpressure: none here; the top only advances when its output stage transfers.
module sq_run_split
    import sq_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic [3:0]    cur_val,
    input  logic [AW-1:0] n,
    input  logic          first_flag,
    output sq_sym_t       sym,
    output logic [AW-1:0] used
);

    always_comb begin
        sym     = '0;
        used    = AW'(1);
        if (cur_val == 4'd0) begin
            if (n >= AW'(REP_Z11_MIN)) begin
                used        = (n > AW'(REP_Z11_MAX)) ? AW'(REP_Z11_MAX) : n;
                sym.sym     = SYM_REP_Z11;
                sym.ext     = 7'(used - AW'(REP_Z11_MIN));
                sym.ext_len = EXT_LEN_Z11;
            end else if (n >= AW'(REP_Z3_MIN)) begin
                used        = (n > AW'(REP_Z3_MAX)) ? AW'(REP_Z3_MAX) : n;
                sym.sym     = SYM_REP_Z3;
                sym.ext     = 7'(used - AW'(REP_Z3_MIN));
                sym.ext_len = EXT_LEN_Z3;
            end
        end else begin
            sym.sym = {1'b0, cur_val};
            // A nonzero run always opens with its literal so a 16 never reaches into the previous run
            if (!first_flag && (n >= AW'(REP_PREV_MIN))) begin
                used        = (n > AW'(REP_PREV_MAX)) ? AW'(REP_PREV_MAX) : n;
                sym.sym     = SYM_REP_PREV;
                sym.ext     = 7'(used - AW'(REP_PREV_MIN));
                sym.ext_len = EXT_LEN_PREV;
            end
        end
    end

endmodule

// File: rtl/sq_compactor.sv
// Scans a code-length buffer and emits the DEFLATE run-length symbol stream (0..18 plus extra bits).
// Latency: 2 cycles per buffer entry while scanning, 1 cycle per emitted symbol.
// Backpressure: sym_vld/payload held until sym_rdy; scanning pauses while a run is being emitted.
module sq_compactor
    import sq_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] num_len,
    output logic [AW-1:0] buff_addr,
    output logic          buff_rd,
    input  logic [DW-1:0] buff_data,
    output logic [4:0]    sym_out,
    output logic [6:0]    ext_out,
    output logic [2:0]    ext_len,
    output logic          sym_vld,
    input  logic          sym_rdy,
    output logic          busy,
    output logic          finish
);

    sq_cmp_state_e state, state_nxt;

    logic [AW-1:0] len_q;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] run_cnt;
    logic [AW-1:0] rem;
    logic [3:0]    cur_val;
    logic [3:0]    pend_val;
    logic          pend_vld;
    logic          scan_first;
    sq_sym_t       out_q;
    logic          sym_vld_q;

    logic [3:0]    data_val;
    logic [3:0]    run_val_c;
    logic [AW-1:0] run_cnt_c;
    logic          differ;
    logic          xfer;
    logic          entries_left;
    logic          load_out;
    logic [3:0]    split_val;
    logic [AW-1:0] split_n;
    logic          split_first;
    sq_sym_t       split_sym;
    logic [AW-1:0] split_used;

    logic          data_unused;
    assign data_unused = ^buff_data[DW-1:4];

    sq_run_split #(.AW(AW)) u_split (
        .cur_val    (split_val),
        .n          (split_n),
        .first_flag (split_first),
        .sym        (split_sym),
        .used       (split_used)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        data_val     = buff_data[3:0];
        run_val_c    = cur_val;
        run_cnt_c    = run_cnt;
        differ       = 1'b0;
        xfer         = sym_vld_q & sym_rdy;
        entries_left = (rd_ptr != len_q);
        load_out     = 1'b0;
        split_val    = cur_val;
        split_n      = rem;
        split_first  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (num_len == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                state_nxt = ST_CMP;
            end
            ST_CMP: begin
                if (scan_first) begin
                    run_val_c = data_val;
                    run_cnt_c = AW'(1);
                end else if (data_val == cur_val) begin
                    run_cnt_c = run_cnt + AW'(1);
                end else begin
                    differ = 1'b1;
                end
                if (differ || !entries_left) begin
                    state_nxt   = ST_EMIT;
                    load_out    = 1'b1;
                    split_val   = run_val_c;
                    split_n     = run_cnt_c;
                    split_first = 1'b1;
                end else begin
                    state_nxt = ST_RD;
                end
            end
            ST_EMIT: begin
                if (xfer) begin
                    if (rem != '0) begin
                        load_out = 1'b1;
                    end else if (pend_vld) begin
                        // Pending entry is already read: keep scanning, or emit it directly if it was the last
                        if (entries_left) begin
                            state_nxt = ST_RD;
                        end else begin
                            load_out    = 1'b1;
                            split_val   = pend_val;
                            split_n     = AW'(1);
                            split_first = 1'b1;
                        end
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            rd_ptr     <= '0;
            run_cnt    <= '0;
            rem        <= '0;
            cur_val    <= '0;
            pend_val   <= '0;
            pend_vld   <= 1'b0;
            scan_first <= 1'b0;
            out_q      <= '0;
            sym_vld_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q      <= num_len;
                        rd_ptr     <= '0;
                        scan_first <= 1'b1;
                        pend_vld   <= 1'b0;
                    end
                end
                ST_RD: begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                ST_CMP: begin
                    scan_first <= 1'b0;
                    cur_val    <= run_val_c;
                    run_cnt    <= run_cnt_c;
                    if (differ) begin
                        pend_val <= data_val;
                        pend_vld <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (xfer && (rem == '0) && pend_vld) begin
                        cur_val  <= pend_val;
                        run_cnt  <= AW'(1);
                        pend_vld <= 1'b0;
                    end
                end
                default: begin
                end
            endcase

            if (load_out) begin
                out_q     <= split_sym;
                rem       <= split_n - split_used;
                sym_vld_q <= 1'b1;
            end else if (xfer) begin
                sym_vld_q <= 1'b0;
            end
        end
    end

    assign buff_rd   = (state == ST_RD);
    assign buff_addr = buff_rd ? rd_ptr : '0;
    assign busy      = (state != ST_IDLE);
    assign finish    = (state == ST_DONE);
    assign sym_vld   = sym_vld_q;
    assign sym_out   = out_q.sym;
    assign ext_out   = out_q.ext;
    assign ext_len   = out_q.ext_len;

endmodule

// File: tb/tb_sq_compactor.sv
// Scoreboard bench: a run-based reference model queues expected symbols and read addresses,
// independent monitors compare every handshake and read against those queues.
module tb_sq_compactor;

    localparam int AW = 9;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] num_len;
    logic [AW-1:0] buff_addr;
    logic          buff_rd;
    logic [DW-1:0] buff_data;
    logic [4:0]    sym_out;
    logic [6:0]    ext_out;
    logic [2:0]    ext_len;
    logic          sym_vld;
    logic          sym_rdy;
    logic          busy;
    logic          finish;

    always #5 clk = ~clk;

    sq_compactor #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_len   (num_len),
        .buff_addr (buff_addr),
        .buff_rd   (buff_rd),
        .buff_data (buff_data),
        .sym_out   (sym_out),
        .ext_out   (ext_out),
        .ext_len   (ext_len),
        .sym_vld   (sym_vld),
        .sym_rdy   (sym_rdy),
        .busy      (busy),
        .finish    (finish)
    );

    typedef struct packed {
        logic [4:0] sym;
        logic [6:0] ext;
        logic [2:0] len;
    } exp_t;

    exp_t          exp_q[$];
    int            addr_q[$];
    logic [DW-1:0] mem [0:511];

    int checks = 0;
    int errors = 0;
    int finish_count = 0;
    int read_count = 0;
    int rdy_mode = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Buffer: data appears one cycle after the read strobe; garbage otherwise
    always @(posedge clk) begin
        logic          r;
        logic [AW-1:0] a;
        r = buff_rd;
        a = buff_addr;
        #1;
        if (r) buff_data = mem[a];
        else   buff_data = DW'($urandom);
    end

    // Ready generator: 0 always ready, 1 random, 2 hold low 5 cycles on every other symbol
    always @(posedge clk) begin
        int seen;
        int stall;
        if (sym_vld && sym_rdy) begin
            seen++;
            stall = 0;
        end
        #1;
        case (rdy_mode)
            0: sym_rdy = 1'b1;
            1: sym_rdy = ($urandom_range(0, 2) != 0);
            default: begin
                if (sym_vld && seen[0] && stall < 5) begin
                    sym_rdy = 1'b0;
                    stall++;
                end else begin
                    sym_rdy = 1'b1;
                end
            end
        endcase
    end

    // Monitor: reads, symbol handshakes, payload stability, finish pulses
    always @(negedge clk) begin
        logic held_vld;
        exp_t held;
        exp_t e;
        if (rst) begin
            held_vld = 1'b0;
        end else begin
            if (buff_rd) begin
                read_count++;
                if (addr_q.size() == 0) check("unexpected_read", 1, 0);
                else check("read_addr", int'(buff_addr), addr_q.pop_front());
            end
            if (held_vld) begin
                check("vld_held", int'(sym_vld), 1);
                if (sym_vld) check("payload_held", int'({sym_out, ext_out, ext_len}), int'(held));
            end
            if (sym_vld && sym_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sym", int'(sym_out), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("sym", int'(sym_out), int'(e.sym));
                    check("ext", int'(ext_out), int'(e.ext));
                    check("ext_len", int'(ext_len), int'(e.len));
                end
                held_vld = 1'b0;
            end else if (sym_vld) begin
                held_vld = 1'b1;
                held = {sym_out, ext_out, ext_len};
            end else begin
                held_vld = 1'b0;
            end
            if (finish) finish_count++;
        end
    end

    task automatic push_sym(input int s, input int x, input int l);
        exp_t e;
        e.sym = 5'(s);
        e.ext = 7'(x);
        e.len = 3'(l);
        exp_q.push_back(e);
    endtask

    // Reference: find maximal runs, then cut each greedily into RLE symbols
    task automatic model(input int n);
        int i, j, v, r, t;
        i = 0;
        while (i < n) begin
            v = int'(mem[i][3:0]);
            j = i;
            while (j < n && int'(mem[j][3:0]) == v) j++;
            r = j - i;
            i = j;
            if (v == 0) begin
                while (r >= 11) begin t = (r > 138) ? 138 : r; push_sym(18, t - 11, 7); r -= t; end
                while (r >= 3)  begin t = (r > 10) ? 10 : r;   push_sym(17, t - 3, 3);  r -= t; end
                while (r > 0)   begin push_sym(0, 0, 0); r--; end
            end else begin
                push_sym(v, 0, 0);
                r--;
                while (r >= 3) begin t = (r > 6) ? 6 : r; push_sym(16, t - 3, 2); r -= t; end
                while (r > 0)  begin push_sym(v, 0, 0); r--; end
            end
        end
        for (int k = 0; k < n; k++) addr_q.push_back(k);
    endtask

    task automatic set_mem(input int idx, input int v);
        mem[idx] = {1'($urandom), 4'(v)};
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sym_vld"}, int'(sym_vld), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_finish"}, int'(finish), 0);
        check({tag, "_buff_rd"}, int'(buff_rd), 0);
        check({tag, "_buff_addr"}, int'(buff_addr), 0);
        check({tag, "_sym_out"}, int'(sym_out), 0);
        check({tag, "_ext_out"}, int'(ext_out), 0);
        check({tag, "_ext_len"}, int'(ext_len), 0);
    endtask

    task automatic run_job(input int n, input int mode);
        int cyc, fbase, rbase;
        rdy_mode = mode;
        model(n);
        fbase = finish_count;
        rbase = read_count;
        @(posedge clk); #1;
        num_len = AW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            check("zero_finish_latency", int'(finish), 1);
        end else begin
            cyc = 0;
            while (!finish && cyc < 20000) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("finish_seen", int'(finish), 1);
        end
        check("busy_at_finish", int'(busy), 1);
        check("syms_done_at_finish", exp_q.size(), 0);
        @(posedge clk); #1;
        check("finish_one_cycle", int'(finish), 0);
        check("busy_after_finish", int'(busy), 0);
        @(negedge clk);
        check("finish_count", finish_count - fbase, 1);
        check("read_count", read_count - rbase, n);
        check("reads_left", addr_q.size(), 0);
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        int n, v, len, cyc, fbase;
        rst = 1'b1;
        start = 1'b0;
        num_len = '0;
        sym_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) set_mem(i, 8);
        run_job(8, 0);

        for (int i = 0; i < 140; i++) set_mem(i, 0);
        run_job(140, 0);

        begin
            int pat[7] = '{3, 3, 0, 0, 0, 5, 0};
            for (int i = 0; i < 7; i++) set_mem(i, pat[i]);
        end
        run_job(7, 0);

        for (int i = 0; i < 19; i++) set_mem(i, (i < 15) ? 0 : 7);
        run_job(19, 1);

        for (int i = 0; i < 140; i++) set_mem(i, 0);
        run_job(140, 2);

        for (int job = 0; job < 8; job++) begin
            n = $urandom_range(1, 320);
            for (int i = 0; i < n; ) begin
                v = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
                len = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 150 : 12);
                for (int k = 0; k < len && i < n; k++) begin
                    set_mem(i, v);
                    i++;
                end
            end
            run_job(n, job % 3);
        end

        // Abort a job mid-emit, then a zero-length job
        for (int i = 0; i < 8; i++) set_mem(i, 8);
        rdy_mode = 2;
        model(8);
        @(posedge clk); #1;
        num_len = AW'(8);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!sym_vld && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reached_emit", int'(sym_vld), 1);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_idle("abort");
        fbase = finish_count;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (4) @(posedge clk);
        #1;
        check("no_finish_after_abort", finish_count - fbase, 0);
        check("idle_after_abort", int'(busy), 0);
        run_job(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("no_sym_after_zero_job", int'(sym_vld), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
